conv2d_frame_ctrl: RTL

//  Raster sequencer for the 3x3 Sobel window datapath (conv2d).
//  - Gates the upstream pixel stream into conv2d one frame at a time.
//  - Tracks the row/column of every accepted pixel.
//  - Emits per-beat window qualifiers: interior-valid, start-of-frame, end-of-frame.

---
 rtl/conv2d_frame_ctrl_pkg.sv | 9 +
 rtl/conv2d_frame_ctrl_if.sv | 8 +
 rtl/conv2d_frame_ctrl_raster_counter.sv | 34 +++
 rtl/conv2d_frame_ctrl.sv | 78 +++++++
 4 files changed

// File: rtl/conv2d_frame_ctrl_pkg.sv
// sobel_pkg: shared types and helpers for the Sobel raster frame controller.
package sobel_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} frame_state_e;
    localparam int KERNEL_SIZE = 3;
    // A 3x3 window is interior once the newest pixel is at least two rows/cols in.
    function automatic logic interior(input int row, input int col, input int w, input int h);
        return row >= KERNEL_SIZE - 1 && col >= KERNEL_SIZE - 1 && row < h && col < w;
    endfunction
endpackage

// File: rtl/conv2d_frame_ctrl_if.sv
// conv2d_frame_ctrl_if: valid/ready pixel stream with producer and consumer views.
interface conv2d_frame_ctrl_if #(parameter int WIDTH_P = 8) ();
    logic               valid;
    logic               ready;
    logic [WIDTH_P-1:0] data;
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/conv2d_frame_ctrl_raster_counter.sv
// raster_counter: column/row position of the next accepted pixel in a frame.
module raster_counter #(
    parameter int IMG_W_P = 16,
    parameter int IMG_H_P = 16,
    localparam int CW = $clog2(IMG_W_P),
    localparam int RW = $clog2(IMG_H_P)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          last_o
);
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_last;
    assign col_last = col_q == CW'(IMG_W_P - 1);
    assign last_o   = col_last && row_q == RW'(IMG_H_P - 1);
    assign col_d    = col_last ? '0 : col_q + CW'(1);
    assign row_d    = last_o ? '0 : col_last ? row_q + RW'(1) : row_q;
    always_ff @(posedge clk_i) begin
        if (!rstn_i || clr_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (inc_i) begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
    assign col_o = col_q;
    assign row_o = row_q;
endmodule

// File: rtl/conv2d_frame_ctrl.sv
// conv2d_frame_ctrl: gates one frame at a time into conv2d and qualifies interior windows.
module conv2d_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int WIDTH_P = 8,
    parameter int IMG_W_P = 16,
    parameter int IMG_H_P = 16,
    parameter int CNT_W_P = 16
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                start_i,
    input  logic                abort_i,
    conv2d_frame_ctrl_if.slave  up_i,
    conv2d_frame_ctrl_if.master dn_o,
    output logic                win_valid_o,
    output logic                win_sof_o,
    output logic                win_eof_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [CNT_W_P-1:0]  frame_cnt_o
);
    localparam int CW = $clog2(IMG_W_P);
    localparam int RW = $clog2(IMG_H_P);
    frame_state_e       state_q;
    logic [CNT_W_P-1:0] frame_cnt_q;
    logic               win_valid_q, win_sof_q, win_eof_q;
    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               run, acc, inc, last, win_d;
    assign run        = state_q == RUN;
    assign up_i.ready = dn_o.ready & run;
    assign dn_o.valid = up_i.valid & run;
    assign dn_o.data  = WIDTH_P'(up_i.data);
    assign acc        = up_i.valid & dn_o.ready & run;
    // An abort in the same cycle wins: the beat is neither counted nor qualified.
    assign inc        = acc & ~abort_i;
    assign win_d      = inc & interior(int'(row), int'(col), IMG_W_P, IMG_H_P);
    raster_counter #(.IMG_W_P(IMG_W_P), .IMG_H_P(IMG_H_P)) u_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .inc_i  (inc),
        .clr_i  (abort_i),
        .col_o  (col),
        .row_o  (row),
        .last_o (last)
    );
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            win_valid_q <= 1'b0;
            win_sof_q   <= 1'b0;
            win_eof_q   <= 1'b0;
        end else begin
            win_valid_q <= win_d;
            win_sof_q   <= win_d && row == RW'(KERNEL_SIZE - 1) && col == CW'(KERNEL_SIZE - 1);
            win_eof_q   <= win_d && last;
            case (state_q)
                IDLE: state_q <= start_i ? RUN : IDLE;
                RUN: begin
                    if (abort_i) state_q <= IDLE;
                    else if (acc && last) begin
                        state_q     <= DONE;
                        frame_cnt_q <= frame_cnt_q + CNT_W_P'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign win_valid_o = win_valid_q;
    assign win_sof_o   = win_sof_q;
    assign win_eof_o   = win_eof_q;
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign frame_cnt_o = frame_cnt_q;
endmodule
